// File: rtl/multicycle_control_pkg.sv
// Shared control definitions: state encodings, opcode/funct values,
// ALU operation codes and datapath mux-select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  // Instruction class latched in DECODE; CLS_NONE is the cleared value.
  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_ADDI    = 3'd4,
    CLS_BEQ     = 3'd5,
    CLS_J       = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOP = 4'b1000;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct classifier. Anything not recognised,
// including an all-zero R-type word, classifies as illegal.
module instr_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0]   op_in,
  input  logic [5:0]   func_in,
  output instr_class_t cls_out,
  output logic [3:0]   alu_op_out
);

  // Classify the instruction and pick the R-type ALU operation.
  always_comb begin
    cls_out    = CLS_ILLEGAL;
    alu_op_out = ALU_NOP;
    case (op_in)
      OP_RTYPE: begin
        case (func_in)
          FN_ADD: begin cls_out = CLS_RTYPE; alu_op_out = ALU_ADD; end
          FN_SUB: begin cls_out = CLS_RTYPE; alu_op_out = ALU_SUB; end
          FN_AND: begin cls_out = CLS_RTYPE; alu_op_out = ALU_AND; end
          FN_OR:  begin cls_out = CLS_RTYPE; alu_op_out = ALU_OR;  end
          FN_SLT: begin cls_out = CLS_RTYPE; alu_op_out = ALU_SLT; end
          default: begin cls_out = CLS_ILLEGAL; alu_op_out = ALU_NOP; end
        endcase
      end
      OP_LW:   cls_out = CLS_LW;
      OP_SW:   cls_out = CLS_SW;
      OP_ADDI: cls_out = CLS_ADDI;
      OP_BEQ:  cls_out = CLS_BEQ;
      OP_J:    cls_out = CLS_J;
      default: cls_out = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit. Moore FSM; strobes decode from the
// registered state and latched class. The only input-dependent strobes are
// the FETCH ir/pc writes (gated by memory completion), the J pc write in
// DECODE (class not latched yet) and the BEQ pc write in EXEC (zero flag).
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_in,
  input  logic [5:0]  op_in,
  input  logic [5:0]  func_in,
  input  logic        zero_in,
  input  logic        mem_ready_in,
  output logic        pc_write_out,
  output logic        ir_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        iord_out,
  output logic        reg_write_out,
  output logic        reg_dst_out,
  output logic        mem_to_reg_out,
  output logic        alu_src_a_out,
  output logic [1:0]  alu_src_b_out,
  output logic [1:0]  pc_src_out,
  output logic [3:0]  alu_cntrl_out,
  output logic [3:0]  state_out,
  output logic        illegal_out,
  output logic [15:0] instr_count_out
);

  state_t       state_q;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic [3:0]   alu_q;
  logic [3:0]   dec_alu;
  logic [15:0]  count_q;
  logic         illegal_q;

  instr_decode u_instr_decode (
    .op_in      (op_in),
    .func_in    (func_in),
    .cls_out    (dec_cls),
    .alu_op_out (dec_alu)
  );

  // State register, latched instruction class, retire counter and trap flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_NONE;
      alu_q     <= ALU_NOP;
      count_q   <= 16'd0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (run_in) state_q <= S_FETCH;
        S_FETCH: if (mem_ready_in) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q <= dec_cls;
          alu_q <= dec_alu;
          case (dec_cls)
            CLS_J: begin
              count_q <= count_q + 16'd1;
              state_q <= run_in ? S_FETCH : S_IDLE;
            end
            CLS_ILLEGAL: begin
              illegal_q <= 1'b1;
              state_q   <= S_TRAP;
            end
            default: state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            CLS_RTYPE, CLS_ADDI: state_q <= S_WB_ALU;
            CLS_LW:              state_q <= S_MEM_RD;
            CLS_SW:              state_q <= S_MEM_WR;
            CLS_BEQ: begin
              count_q <= count_q + 16'd1;
              state_q <= run_in ? S_FETCH : S_IDLE;
            end
            default: begin
              illegal_q <= 1'b1;
              state_q   <= S_TRAP;
            end
          endcase
        end
        S_MEM_RD: if (mem_ready_in) state_q <= S_WB_MEM;
        S_MEM_WR: begin
          if (mem_ready_in) begin
            count_q <= count_q + 16'd1;
            state_q <= run_in ? S_FETCH : S_IDLE;
          end
        end
        S_WB_ALU, S_WB_MEM: begin
          count_q <= count_q + 16'd1;
          state_q <= run_in ? S_FETCH : S_IDLE;
        end
        S_TRAP: state_q <= S_TRAP;
        default: begin
          illegal_q <= 1'b1;
          state_q   <= S_TRAP;
        end
      endcase
    end
  end

  // Datapath strobes and selects from the current state.
  always_comb begin
    pc_write_out   = 1'b0;
    ir_write_out   = 1'b0;
    mem_read_out   = 1'b0;
    mem_write_out  = 1'b0;
    iord_out       = 1'b0;
    reg_write_out  = 1'b0;
    reg_dst_out    = 1'b0;
    mem_to_reg_out = 1'b0;
    alu_src_a_out  = 1'b0;
    alu_src_b_out  = SRCB_REG;
    pc_src_out     = PCSRC_ALU;
    alu_cntrl_out  = ALU_NOP;
    case (state_q)
      S_FETCH: begin
        mem_read_out  = 1'b1;
        alu_src_b_out = SRCB_FOUR;
        alu_cntrl_out = ALU_ADD;
        ir_write_out  = mem_ready_in;
        pc_write_out  = mem_ready_in;
      end
      S_DECODE: begin
        alu_src_b_out = SRCB_IMM_SH2;
        alu_cntrl_out = ALU_ADD;
        if (dec_cls == CLS_J) begin
          pc_write_out = 1'b1;
          pc_src_out   = PCSRC_JUMP;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_RTYPE: begin
            alu_src_a_out = 1'b1;
            alu_src_b_out = SRCB_REG;
            alu_cntrl_out = alu_q;
          end
          CLS_LW, CLS_SW, CLS_ADDI: begin
            alu_src_a_out = 1'b1;
            alu_src_b_out = SRCB_IMM;
            alu_cntrl_out = ALU_ADD;
          end
          CLS_BEQ: begin
            alu_src_a_out = 1'b1;
            alu_src_b_out = SRCB_REG;
            alu_cntrl_out = ALU_SUB;
            pc_src_out    = PCSRC_ALUOUT;
            pc_write_out  = zero_in;
          end
          default: alu_cntrl_out = ALU_NOP;
        endcase
      end
      S_MEM_RD: begin
        iord_out     = 1'b1;
        mem_read_out = 1'b1;
      end
      S_MEM_WR: begin
        iord_out      = 1'b1;
        mem_write_out = 1'b1;
      end
      S_WB_ALU: begin
        reg_write_out = 1'b1;
        reg_dst_out   = (cls_q == CLS_RTYPE);
      end
      S_WB_MEM: begin
        reg_write_out  = 1'b1;
        mem_to_reg_out = 1'b1;
      end
      default: alu_cntrl_out = ALU_NOP;
    endcase
  end

  assign state_out       = state_q;
  assign illegal_out     = illegal_q;
  assign instr_count_out = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through the FSM and compares states and strobes with hand-derived values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n, run_in, zero_in, mem_ready_in;
  logic [5:0]  op_in, func_in;
  logic        pc_write_out, ir_write_out, mem_read_out, mem_write_out, iord_out;
  logic        reg_write_out, reg_dst_out, mem_to_reg_out, alu_src_a_out;
  logic [1:0]  alu_src_b_out, pc_src_out;
  logic [3:0]  alu_cntrl_out, state_out;
  logic        illegal_out;
  logic [15:0] instr_count_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_count;
  logic [3:0]  exp_q[$];

  logic [5:0]  fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0]  alu_tab [5] = '{4'b0000,   4'b0001,   4'b0010,   4'b0101,   4'b0100};

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  multicycle_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run_in          (run_in),
    .op_in           (op_in),
    .func_in         (func_in),
    .zero_in         (zero_in),
    .mem_ready_in    (mem_ready_in),
    .pc_write_out    (pc_write_out),
    .ir_write_out    (ir_write_out),
    .mem_read_out    (mem_read_out),
    .mem_write_out   (mem_write_out),
    .iord_out        (iord_out),
    .reg_write_out   (reg_write_out),
    .reg_dst_out     (reg_dst_out),
    .mem_to_reg_out  (mem_to_reg_out),
    .alu_src_a_out   (alu_src_a_out),
    .alu_src_b_out   (alu_src_b_out),
    .pc_src_out      (pc_src_out),
    .alu_cntrl_out   (alu_cntrl_out),
    .state_out       (state_out),
    .illegal_out     (illegal_out),
    .instr_count_out (instr_count_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and step just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check queued states, one per cycle.
  task automatic drain_states();
    while (exp_q.size() > 0) begin
      #1;
      check("state_seq", 16'(state_out), 16'(exp_q.pop_front()));
      tick();
    end
  endtask

  task automatic check_strobes_off(input string tag);
    check({tag, "_mem_read"},  16'(mem_read_out),  16'd0);
    check({tag, "_mem_write"}, 16'(mem_write_out), 16'd0);
    check({tag, "_reg_write"}, 16'(reg_write_out), 16'd0);
    check({tag, "_pc_write"},  16'(pc_write_out),  16'd0);
    check({tag, "_ir_write"},  16'(ir_write_out),  16'd0);
  endtask

  initial begin
    rst_n = 1'b0; run_in = 1'b0; op_in = 6'd0; func_in = 6'd0;
    zero_in = 1'b0; mem_ready_in = 1'b1;
    exp_count = 16'd0;
    tick(); tick();

    // Reset state
    #1;
    check("rst_state",   16'(state_out),   16'd0);
    check("rst_count",   instr_count_out,  16'd0);
    check("rst_illegal", 16'(illegal_out), 16'd0);
    check_strobes_off("rst");

    // First cycle after reset, run requested: still idle, strobes quiet
    rst_n = 1'b1; run_in = 1'b1; op_in = 6'b000000; func_in = 6'b100000;
    #1;
    check("post_rst_state", 16'(state_out), 16'd0);
    check_strobes_off("post_rst");
    tick();

    // ADD: FETCH, DECODE, EXEC, WB_ALU
    #1;
    check("add_fetch_state", 16'(state_out),     16'd1);
    check("add_fetch_rd",    16'(mem_read_out),  16'd1);
    check("add_fetch_iord",  16'(iord_out),      16'd0);
    check("add_fetch_ir",    16'(ir_write_out),  16'd1);
    check("add_fetch_pc",    16'(pc_write_out),  16'd1);
    check("add_fetch_srcb",  16'(alu_src_b_out), 16'd1);
    check("add_fetch_alu",   16'(alu_cntrl_out), 16'd0);
    tick();
    #1;
    check("add_dec_state", 16'(state_out),     16'd2);
    check("add_dec_srcb",  16'(alu_src_b_out), 16'd3);
    check("add_dec_pcw",   16'(pc_write_out),  16'd0);
    tick();
    #1;
    check("add_exec_state", 16'(state_out),     16'd3);
    check("add_exec_srca",  16'(alu_src_a_out), 16'd1);
    check("add_exec_srcb",  16'(alu_src_b_out), 16'd0);
    check("add_exec_alu",   16'(alu_cntrl_out), 16'd0);
    tick();
    #1;
    check("add_wb_state", 16'(state_out),      16'd6);
    check("add_wb_regw",  16'(reg_write_out),  16'd1);
    check("add_wb_dst",   16'(reg_dst_out),    16'd1);
    check("add_wb_m2r",   16'(mem_to_reg_out), 16'd0);
    tick();
    exp_count = 16'd1;
    #1;
    check("add_count", instr_count_out, exp_count);
    check("add_next",  16'(state_out),  16'd1);

    // R-type table: ALU control chosen by funct
    for (int i = 0; i < 5; i++) begin
      func_in = fn_tab[i];
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd2);
      drain_states();
      #1;
      check("rt_exec_state", 16'(state_out),     16'd3);
      check("rt_exec_alu",   16'(alu_cntrl_out), 16'(alu_tab[i]));
      tick();
      exp_q.push_back(4'd6);
      drain_states();
      exp_count = exp_count + 16'd1;
    end
    check("rt_count", instr_count_out, exp_count);

    // LW with two memory wait cycles; op_in disturbed after DECODE
    op_in = 6'b100011;
    tick(); tick();
    #1;
    check("lw_exec_state", 16'(state_out),     16'd3);
    check("lw_exec_srcb",  16'(alu_src_b_out), 16'd2);
    check("lw_exec_alu",   16'(alu_cntrl_out), 16'd0);
    tick();
    mem_ready_in = 1'b0; op_in = 6'b111111;
    #1;
    check("lw_mrd_state", 16'(state_out),    16'd4);
    check("lw_mrd_iord",  16'(iord_out),     16'd1);
    check("lw_mrd_rd",    16'(mem_read_out), 16'd1);
    tick();
    #1;
    check("lw_wait2_state", 16'(state_out), 16'd4);
    tick();
    mem_ready_in = 1'b1;
    #1;
    check("lw_wait3_state", 16'(state_out), 16'd4);
    tick();
    #1;
    check("lw_wb_state", 16'(state_out),      16'd7);
    check("lw_wb_m2r",   16'(mem_to_reg_out), 16'd1);
    check("lw_wb_regw",  16'(reg_write_out),  16'd1);
    check("lw_wb_dst",   16'(reg_dst_out),    16'd0);
    tick();
    exp_count = exp_count + 16'd1;
    op_in = 6'b000100; zero_in = 1'b1;
    #1;
    check("lw_done_state",   16'(state_out),   16'd1);
    check("lw_done_illegal", 16'(illegal_out), 16'd0);
    check("lw_count",        instr_count_out,  exp_count);

    // BEQ taken then not taken
    tick(); tick();
    #1;
    check("beq1_state",  16'(state_out),     16'd3);
    check("beq1_pcw",    16'(pc_write_out),  16'd1);
    check("beq1_pcsrc",  16'(pc_src_out),    16'd1);
    check("beq1_alu",    16'(alu_cntrl_out), 16'd1);
    tick();
    exp_count = exp_count + 16'd1;
    zero_in = 1'b0;
    #1;
    check("beq1_next",  16'(state_out), 16'd1);
    check("beq1_count", instr_count_out, exp_count);
    tick(); tick();
    #1;
    check("beq0_state", 16'(state_out),    16'd3);
    check("beq0_pcw",   16'(pc_write_out), 16'd0);
    tick();
    exp_count = exp_count + 16'd1;
    op_in = 6'b000010;
    #1;
    check("beq0_count", instr_count_out, exp_count);

    // J completes in DECODE
    tick();
    #1;
    check("j_state", 16'(state_out),    16'd2);
    check("j_pcw",   16'(pc_write_out), 16'd1);
    check("j_pcsrc", 16'(pc_src_out),   16'd2);
    tick();
    exp_count = exp_count + 16'd1;
    op_in = 6'b001000;
    #1;
    check("j_next",  16'(state_out), 16'd1);
    check("j_count", instr_count_out, exp_count);

    // ADDI writes rt (reg_dst 0)
    tick(); tick();
    #1;
    check("addi_srcb", 16'(alu_src_b_out), 16'd2);
    check("addi_srca", 16'(alu_src_a_out), 16'd1);
    tick();
    #1;
    check("addi_wb_state", 16'(state_out),   16'd6);
    check("addi_wb_dst",   16'(reg_dst_out), 16'd0);
    tick();
    exp_count = exp_count + 16'd1;
    op_in = 6'b101011;

    // SW with run dropped during MEM_WR
    tick(); tick(); tick();
    mem_ready_in = 1'b0; run_in = 1'b0;
    #1;
    check("sw_state", 16'(state_out),     16'd5);
    check("sw_wr",    16'(mem_write_out), 16'd1);
    check("sw_iord",  16'(iord_out),      16'd1);
    check("sw_rd",    16'(mem_read_out),  16'd0);
    tick();
    mem_ready_in = 1'b1;
    #1;
    check("sw_hold", 16'(state_out), 16'd5);
    tick();
    exp_count = exp_count + 16'd1;
    #1;
    check("sw_idle",  16'(state_out), 16'd0);
    check("sw_count", instr_count_out, exp_count);

    // Counter wrap: preset 0xFFFF, retire one J
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    #1;
    check("wrap_preset", instr_count_out, 16'hFFFF);
    run_in = 1'b1; op_in = 6'b000010;
    tick(); tick();
    run_in = 1'b0;
    tick();
    #1;
    check("wrap_count", instr_count_out, 16'h0000);
    check("wrap_idle",  16'(state_out),  16'd0);

    // Fetch wait then illegal opcode traps
    run_in = 1'b1; op_in = 6'b111111; mem_ready_in = 1'b0;
    tick();
    #1;
    check("fwait_state", 16'(state_out),    16'd1);
    check("fwait_ir",    16'(ir_write_out), 16'd0);
    check("fwait_rd",    16'(mem_read_out), 16'd1);
    tick();
    mem_ready_in = 1'b1;
    tick(); tick();
    #1;
    check("trap_state",   16'(state_out),   16'd8);
    check("trap_illegal", 16'(illegal_out), 16'd1);
    check("trap_count",   instr_count_out,  16'h0000);
    check_strobes_off("trap");
    tick();
    #1;
    check("trap_stay", 16'(state_out), 16'd8);

    // Reset out of TRAP
    rst_n = 1'b0;
    tick();
    #1;
    check("trap_rst_state",   16'(state_out),   16'd0);
    check("trap_rst_illegal", 16'(illegal_out), 16'd0);

    // op 0 / func 0 is illegal
    rst_n = 1'b1; op_in = 6'b000000; func_in = 6'b000000;
    tick(); tick(); tick();
    #1;
    check("nop_trap_state",   16'(state_out),   16'd8);
    check("nop_trap_illegal", 16'(illegal_out), 16'd1);

    // Reset during a memory wait
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; op_in = 6'b100011;
    tick(); tick(); tick(); tick();
    mem_ready_in = 1'b0;
    #1;
    check("mwait_state", 16'(state_out), 16'd4);
    rst_n = 1'b0;
    tick();
    #1;
    check("mwait_rst_state", 16'(state_out),      16'd0);
    check("mwait_rst_count", instr_count_out,     16'h0000);
    check_strobes_off("mwait_rst");
    rst_n = 1'b1; run_in = 1'b0;
    #1;
    check_strobes_off("mwait_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
